// File: rtl/tap_route_pkg.sv
// Shared types for the tap_route TAP controller: the 16-state encoding seen on the observation pads.
package tap_route_pkg;

   localparam int TAP_STATES = 16;

   typedef enum logic [3:0] {
      TLR      = 4'h0,
      RTI      = 4'h1,
      SEL_DR   = 4'h2,
      CAP_DR   = 4'h3,
      SH_DR    = 4'h4,
      EX1_DR   = 4'h5,
      PAUSE_DR = 4'h6,
      EX2_DR   = 4'h7,
      UPD_DR   = 4'h8,
      SEL_IR   = 4'h9,
      CAP_IR   = 4'hA,
      SH_IR    = 4'hB,
      EX1_IR   = 4'hC,
      PAUSE_IR = 4'hD,
      EX2_IR   = 4'hE,
      UPD_IR   = 4'hF
   } tap_state_t;

endpackage

// File: rtl/tap_route_pulse_capture.sv
// TMS pulse-to-level capture flop, used only when TAP_ROUTE_PULSE_TMS_EN is defined.
module tap_pulse_capture (
   input  logic clk,
   input  logic rst,
   input  logic tms,
   output logic tms_level
);

   // Any high pulse sets the flop; the clock edge that consumes it clears it, unless TMS is still high.
   always_ff @(posedge clk or posedge rst or posedge tms) begin
      if (rst) begin
         tms_level <= 1'b0;
      end else if (tms) begin
         tms_level <= 1'b1;
      end else begin
         tms_level <= 1'b0;
      end
   end

endmodule

// File: rtl/tap_route.sv
// IEEE 1149.1 TAP state machine with the state code on four pads.
// Define TAP_ROUTE_PULSE_TMS_EN to treat TMS_Pad as pulse-encoded instead of a sampled level.
module tap_route
   import tap_route_pkg::*;
#(
   parameter logic [3:0] RST_STATE = 4'h0
) (
   input  logic GCLK_Pad,
   input  logic TRST_Pad,
   input  logic TMS_Pad,
   output logic state_obs0_Pad,
   output logic state_obs1_Pad,
   output logic state_obs2_Pad,
   output logic state_obs3_Pad
);

   tap_state_t state;
   tap_state_t next_state;
   logic       tms_eff;

`ifdef TAP_ROUTE_PULSE_TMS_EN
   tap_pulse_capture u_capture (
      .clk       (GCLK_Pad),
      .rst       (TRST_Pad),
      .tms       (TMS_Pad),
      .tms_level (tms_eff)
   );
`else
   assign tms_eff = TMS_Pad;
`endif

   always_comb begin
      next_state = TLR;
      case (state)
         TLR:      next_state = tms_eff ? TLR      : RTI;
         RTI:      next_state = tms_eff ? SEL_DR   : RTI;
         SEL_DR:   next_state = tms_eff ? SEL_IR   : CAP_DR;
         CAP_DR:   next_state = tms_eff ? EX1_DR   : SH_DR;
         SH_DR:    next_state = tms_eff ? EX1_DR   : SH_DR;
         EX1_DR:   next_state = tms_eff ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: next_state = tms_eff ? EX2_DR   : PAUSE_DR;
         EX2_DR:   next_state = tms_eff ? UPD_DR   : SH_DR;
         UPD_DR:   next_state = tms_eff ? SEL_DR   : RTI;
         SEL_IR:   next_state = tms_eff ? TLR      : CAP_IR;
         CAP_IR:   next_state = tms_eff ? EX1_IR   : SH_IR;
         SH_IR:    next_state = tms_eff ? EX1_IR   : SH_IR;
         EX1_IR:   next_state = tms_eff ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: next_state = tms_eff ? EX2_IR   : PAUSE_IR;
         EX2_IR:   next_state = tms_eff ? UPD_IR   : SH_IR;
         UPD_IR:   next_state = tms_eff ? SEL_DR   : RTI;
         default:  next_state = TLR;
      endcase
   end

   always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
      if (TRST_Pad) begin
         state <= tap_state_t'(RST_STATE);
      end else begin
         state <= next_state;
      end
   end

   // Pads come straight off the state flops so nothing combinational reaches them from TMS.
   assign state_obs0_Pad = state[0];
   assign state_obs1_Pad = state[1];
   assign state_obs2_Pad = state[2];
   assign state_obs3_Pad = state[3];

endmodule

// File: tb/tb_tap_route.sv
// Directed bench for tap_route: reset, idle, DR/IR walks, TMS escape and mid-operation reset.
`timescale 1ns/1ps
module tb_tap_route;

   logic GCLK_Pad = 1'b0;
   logic TRST_Pad = 1'b0;
   logic TMS_Pad  = 1'b0;
   logic state_obs0_Pad, state_obs1_Pad, state_obs2_Pad, state_obs3_Pad;
   logic [3:0] obs;

   int checks   = 0;
   int failures = 0;

   tap_route dut (
      .GCLK_Pad       (GCLK_Pad),
      .TRST_Pad       (TRST_Pad),
      .TMS_Pad        (TMS_Pad),
      .state_obs0_Pad (state_obs0_Pad),
      .state_obs1_Pad (state_obs1_Pad),
      .state_obs2_Pad (state_obs2_Pad),
      .state_obs3_Pad (state_obs3_Pad)
   );

   assign obs = {state_obs3_Pad, state_obs2_Pad, state_obs1_Pad, state_obs0_Pad};

   always #5 GCLK_Pad = ~GCLK_Pad;

   // Present one TMS value mid-cycle, then sample just after the following rising edge.
   task automatic drive_edge(input logic t);
      @(negedge GCLK_Pad);
`ifdef TAP_ROUTE_PULSE_TMS_EN
      TMS_Pad = t;
      #0.002;
      TMS_Pad = 1'b0;
`else
      TMS_Pad = t;
`endif
      @(posedge GCLK_Pad);
      #1;
   endtask

   task automatic test_reset;
      #3;
      TRST_Pad = 1'b1;
      #1;
      checks++;
      if (obs !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_async obs=%b expected=%b", obs, 4'b0000);
      end
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b1);
         checks++;
         if (obs !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_hold[%0d] obs=%b expected=%b", i, obs, 4'b0000);
         end
      end
      @(negedge GCLK_Pad);
      TRST_Pad = 1'b0;
   endtask

   task automatic test_idle_entry;
      for (int i = 0; i < 6; i++) begin
         drive_edge(1'b0);
         checks++;
         if (obs !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL idle[%0d] obs=%b expected=%b", i, obs, 4'b0001);
         end
      end
   endtask

   task automatic test_dr_walk;
      logic       tms_v [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [3:0] exp_v [9] = '{4'b0010, 4'b0011, 4'b0100, 4'b0100, 4'b0101,
                                4'b0110, 4'b0111, 4'b1000, 4'b0001};
      for (int i = 0; i < 9; i++) begin
         drive_edge(tms_v[i]);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("[TB] FAIL dr_walk[%0d] obs=%b expected=%b", i, obs, exp_v[i]);
         end
      end
   endtask

   task automatic test_ir_walk;
      logic       tms_v [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] exp_v [9] = '{4'b0010, 4'b1001, 4'b1010, 4'b1011, 4'b1100,
                                4'b1101, 4'b1110, 4'b1111, 4'b0010};
      for (int i = 0; i < 9; i++) begin
         drive_edge(tms_v[i]);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("[TB] FAIL ir_walk[%0d] obs=%b expected=%b", i, obs, exp_v[i]);
         end
      end
   endtask

   // From SelDR: walk to ShIR, escape with five ones, then TLR->RTI->SelDR->SelIR->TLR.
   task automatic test_escape;
      logic       tms_v [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] exp_v [12] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1111, 4'b0010,
                                 4'b1001, 4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b0000};
      for (int i = 0; i < 12; i++) begin
         drive_edge(tms_v[i]);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("[TB] FAIL escape[%0d] obs=%b expected=%b", i, obs, exp_v[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic       tms_v [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) drive_edge(tms_v[i]);
      checks++;
      if (obs !== 4'b0110) begin
         failures++;
         $display("[TB] FAIL pause_dr_entry obs=%b expected=%b", obs, 4'b0110);
      end
      @(negedge GCLK_Pad);
      TMS_Pad  = 1'b0;
      TRST_Pad = 1'b1;
      #1;
      checks++;
      if (obs !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_mid obs=%b expected=%b", obs, 4'b0000);
      end
      #1;
      TRST_Pad = 1'b0;
      @(posedge GCLK_Pad);
      #1;
      checks++;
      if (obs !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL reset_release obs=%b expected=%b", obs, 4'b0001);
      end
   endtask

   initial begin
      test_reset();
      test_idle_entry();
      test_dr_walk();
      test_ir_walk();
      test_escape();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
